// File: rtl/finger_scan_ctrl.sv
// finger_scan_ctrl: scans the finger strip above a detected palm in the
// binary hand frame buffer. It reads one pixel per cycle, splits the palm
// column span into five equal bands (thumb..pinky), counts the foreground
// pixels in each band, and registers a five-bit extended/folded status.
// Optional build macro: FINGER_COUNT_OUT_EN adds finger_count[2:0], the
// number of extended fingers.
module finger_scan_ctrl #(
  parameter int                 FINGER_ROWS = 32,
  parameter int                 CNT_W       = 16,
  parameter logic [CNT_W-1:0]   THRESH      = 16'd24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] palm_width,
  input  logic [7:0] start_of_palm_r,
  input  logic [7:0] start_of_palm_c,
  input  logic [7:0] end_of_palm_c,
  output logic       rd_en,
  output logic [7:0] rd_row,
  output logic [7:0] rd_col,
  input  logic       rd_data,
  output logic       busy,
  output logic       done,
  output logic       thumb_status,
  output logic       index_status,
  output logic       middle_status,
  output logic       ring_status,
`ifdef FINGER_COUNT_OUT_EN
  output logic       pinky_status,
  output logic [2:0] finger_count
`else
  output logic       pinky_status
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SCAN, S_DRAIN, S_DECIDE, S_DONE
  } state_t;

  localparam logic [8:0] ROWS9 = 9'(FINGER_ROWS);
  localparam logic [7:0] ROWS8 = 8'(FINGER_ROWS);

  state_t           state_q, state_d;
  logic [7:0]       row_q, row_d;
  logic [7:0]       col_q, col_d;
  logic [7:0]       start_r_q, start_r_d;
  logic [7:0]       start_c_q, start_c_d;
  logic [7:0]       end_c_q, end_c_d;
  logic             wzero_q, wzero_d;
  logic [7:0]       row_hi_q, row_hi_d;
  logic [8:0]       cols_q, cols_d;
  logic [2:0]       band_q, band_d;
  logic [8:0]       acc_q, acc_d;
  logic [2:0]       band_dly_q, band_dly_d;
  logic             rd_en_dly_q, rd_en_dly_d;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];
  logic [4:0]       status_q, status_d;

  logic [7:0]       row_lo;
  logic [8:0]       acc_sum;
  logic             degenerate;
  logic             last_addr;

  // First scanned row: FINGER_ROWS above the palm top, clipped at row 0.
  assign row_lo     = ({1'b0, start_r_q} < ROWS9) ? 8'd0 : (start_r_q - ROWS8);
  assign degenerate = wzero_q || (end_c_q < start_c_q) || (start_r_q == 8'd0);
  assign last_addr  = (row_q == row_hi_q) && (col_q == end_c_q);
  assign acc_sum    = acc_q + 9'd5;

  // State register plus all datapath flops; one synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      start_r_q   <= '0;
      start_c_q   <= '0;
      end_c_q     <= '0;
      wzero_q     <= 1'b0;
      row_hi_q    <= '0;
      cols_q      <= '0;
      band_q      <= '0;
      acc_q       <= '0;
      band_dly_q  <= '0;
      rd_en_dly_q <= 1'b0;
      status_q    <= '0;
      // NOTE: the five counters are a tiny flop array, not a RAM, so they are reset like any other state.
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      start_r_q   <= start_r_d;
      start_c_q   <= start_c_d;
      end_c_q     <= end_c_d;
      wzero_q     <= wzero_d;
      row_hi_q    <= row_hi_d;
      cols_q      <= cols_d;
      band_q      <= band_d;
      acc_q       <= acc_d;
      band_dly_q  <= band_dly_d;
      rd_en_dly_q <= rd_en_dly_d;
      status_q    <= status_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Next-state logic for the scan sequence.
  always_comb begin
    // NOTE: assigning a default first keeps this block free of inferred latches.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_SETUP;
      S_SETUP:  state_d = degenerate ? S_DECIDE : S_SCAN;
      S_SCAN:   if (last_addr) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_DECIDE;
      S_DECIDE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: input capture, address walk, band tracking, counting, decision.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    start_r_d   = start_r_q;
    start_c_d   = start_c_q;
    end_c_d     = end_c_q;
    wzero_d     = wzero_q;
    row_hi_d    = row_hi_q;
    cols_d      = cols_q;
    band_d      = band_q;
    acc_d       = acc_q;
    band_dly_d  = band_q;
    rd_en_dly_d = rd_en;
    status_d    = status_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i];
      // Count a returned foreground pixel into the band its address belonged to.
      if (rd_en_dly_q && rd_data && (band_dly_q == 3'(i)) && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_r_d = start_of_palm_r;
          start_c_d = start_of_palm_c;
          end_c_d   = end_of_palm_c;
          wzero_d   = (palm_width == 8'd0);
        end
      end
      S_SETUP: begin
        row_d    = row_lo;
        col_d    = start_c_q;
        row_hi_d = start_r_q - 8'd1;
        cols_d   = {1'b0, end_c_q} - {1'b0, start_c_q} + 9'd1;
        band_d   = '0;
        acc_d    = '0;
        for (int i = 0; i < 5; i++) cnt_d[i] = '0;
      end
      S_SCAN: begin
        if (col_q == end_c_q) begin
          // Row wrap: restart the column and the band tracker.
          col_d  = start_c_q;
          row_d  = row_q + 8'd1;
          band_d = '0;
          acc_d  = '0;
        end else begin
          col_d = col_q + 8'd1;
          // Each column advances by 5/cols of a band; carry into the next band.
          if (acc_sum >= cols_q) begin
            acc_d  = acc_sum - cols_q;
            band_d = (band_q == 3'd4) ? 3'd4 : band_q + 3'd1;
          end else begin
            acc_d  = acc_sum;
          end
        end
      end
      S_DECIDE: begin
        for (int i = 0; i < 5; i++) status_d[i] = (cnt_q[i] >= THRESH);
      end
      default: ;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    rd_en = (state_q == S_SCAN);
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
  end

  assign rd_row        = row_q;
  assign rd_col        = col_q;
  assign thumb_status  = status_q[0];
  assign index_status  = status_q[1];
  assign middle_status = status_q[2];
  assign ring_status   = status_q[3];
  assign pinky_status  = status_q[4];

`ifdef FINGER_COUNT_OUT_EN
  logic [2:0] fcount_q, fcount_d;

  // Extended-finger count, registered on the same edge as the status bits.
  always_comb begin
    fcount_d = fcount_q;
    if (state_q == S_DECIDE) begin
      fcount_d = '0;
      for (int i = 0; i < 5; i++) fcount_d = fcount_d + 3'(status_d[i]);
    end
  end

  // Finger count register.
  always_ff @(posedge clk) begin
    if (!rst) fcount_q <= '0;
    else      fcount_q <= fcount_d;
  end

  assign finger_count = fcount_q;
`endif

endmodule

// File: tb/tb_finger_scan_ctrl.sv
// Directed bench for finger_scan_ctrl. Three instances run in lockstep with
// THRESH = 24 (default), 10 and 11; each has its own one-cycle-latency
// frame-buffer model driven from a synthetic hand pattern.
module tb_finger_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] palm_width, sr, sc, ec;
  int         pat;          // 0: all foreground, 1: fist (cols 30..39 only)

  logic       rd_en_a, rd_en_b, rd_en_c;
  logic [7:0] rd_row_a, rd_row_b, rd_row_c, rd_col_a, rd_col_b, rd_col_c;
  logic       rd_data_a, rd_data_b, rd_data_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic       th_a, ix_a, md_a, rg_a, pk_a;
  logic       th_b, ix_b, md_b, rg_b, pk_b;
  logic       th_c, ix_c, md_c, rg_c, pk_c;
`ifdef FINGER_COUNT_OUT_EN
  logic [2:0] fc_a, fc_b, fc_c;
`endif
  logic [4:0] st_a, st_b, st_c;   // {pinky, ring, middle, index, thumb}

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign st_a = {pk_a, rg_a, md_a, ix_a, th_a};
  assign st_b = {pk_b, rg_b, md_b, ix_b, th_b};
  assign st_c = {pk_c, rg_c, md_c, ix_c, th_c};

  finger_scan_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start), .palm_width(palm_width),
    .start_of_palm_r(sr), .start_of_palm_c(sc), .end_of_palm_c(ec),
    .rd_en(rd_en_a), .rd_row(rd_row_a), .rd_col(rd_col_a), .rd_data(rd_data_a),
    .busy(busy_a), .done(done_a),
    .thumb_status(th_a), .index_status(ix_a), .middle_status(md_a),
    .ring_status(rg_a),
`ifdef FINGER_COUNT_OUT_EN
    .finger_count(fc_a),
`endif
    .pinky_status(pk_a));

  finger_scan_ctrl #(.THRESH(16'd10)) dut_b (
    .clk(clk), .rst(rst), .start(start), .palm_width(palm_width),
    .start_of_palm_r(sr), .start_of_palm_c(sc), .end_of_palm_c(ec),
    .rd_en(rd_en_b), .rd_row(rd_row_b), .rd_col(rd_col_b), .rd_data(rd_data_b),
    .busy(busy_b), .done(done_b),
    .thumb_status(th_b), .index_status(ix_b), .middle_status(md_b),
    .ring_status(rg_b),
`ifdef FINGER_COUNT_OUT_EN
    .finger_count(fc_b),
`endif
    .pinky_status(pk_b));

  finger_scan_ctrl #(.THRESH(16'd11)) dut_c (
    .clk(clk), .rst(rst), .start(start), .palm_width(palm_width),
    .start_of_palm_r(sr), .start_of_palm_c(sc), .end_of_palm_c(ec),
    .rd_en(rd_en_c), .rd_row(rd_row_c), .rd_col(rd_col_c), .rd_data(rd_data_c),
    .busy(busy_c), .done(done_c),
    .thumb_status(th_c), .index_status(ix_c), .middle_status(md_c),
    .ring_status(rg_c),
`ifdef FINGER_COUNT_OUT_EN
    .finger_count(fc_c),
`endif
    .pinky_status(pk_c));

  function automatic logic pix(input int p, input logic [7:0] r, input logic [7:0] c);
    if (p == 0) return (r <= 8'd255);
    if (p == 1) return (c >= 8'd30) && (c <= 8'd39);
    return 1'b0;
  endfunction

  // Frame buffer models: data appears one cycle after the read strobe.
  always @(posedge clk) rd_data_a <= rd_en_a && pix(pat, rd_row_a, rd_col_a);
  always @(posedge clk) rd_data_b <= rd_en_b && pix(pat, rd_row_b, rd_col_b);
  always @(posedge clk) rd_data_c <= rd_en_c && pix(pat, rd_row_c, rd_col_c);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full request: pulse start, follow the scan edge by edge, check the result.
  task automatic run_scan(input string tag, input logic [7:0] r, input logic [7:0] c0,
                          input logic [7:0] c1, input logic [7:0] w,
                          input int exp_reads, input int exp_done,
                          input logic [4:0] ea, input logic [4:0] eb, input logic [4:0] ecc);
    int edge_n, reads, n_done, done_at;
    logic [7:0] r_first, c_first, r_last, c_last;
    logic timeout;
    reads = 0; n_done = 0; done_at = -1; timeout = 1'b0;
    r_first = '0; c_first = '0; r_last = '0; c_last = '0;
    @(negedge clk);
    sr = r; sc = c0; ec = c1; palm_width = w; start = 1'b1;
    @(posedge clk);
    edge_n = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en_a) begin
        if (reads == 0) begin r_first = rd_row_a; c_first = rd_col_a; end
        r_last = rd_row_a; c_last = rd_col_a;
        reads++;
      end
      if (done_a) begin
        n_done++;
        if (done_at < 0) done_at = edge_n;
      end
      if (n_done > 0 && !busy_a) break;
      if (edge_n > 4000) begin timeout = 1'b1; break; end
      @(posedge clk);
      edge_n++;
    end
    check({tag, "/timeout"}, 32'(timeout), 32'd0);
    check({tag, "/reads"},   32'(reads),   32'(exp_reads));
    check({tag, "/done_at"}, 32'(done_at), 32'(exp_done));
    check({tag, "/n_done"},  32'(n_done),  32'd1);
    check({tag, "/st_a"},    32'(st_a),    32'(ea));
    check({tag, "/st_b"},    32'(st_b),    32'(eb));
    check({tag, "/st_c"},    32'(st_c),    32'(ecc));
`ifdef FINGER_COUNT_OUT_EN
    check({tag, "/fc_a"},    32'(fc_a),    32'($countones(ea)));
    check({tag, "/fc_b"},    32'(fc_b),    32'($countones(eb)));
`endif
    if (exp_reads > 0) begin
      check({tag, "/row_first"}, 32'(r_first), (int'(r) < 32) ? 32'd0 : 32'(int'(r) - 32));
      check({tag, "/col_first"}, 32'(c_first), 32'(c0));
      check({tag, "/row_last"},  32'(r_last),  32'(int'(r) - 1));
      check({tag, "/col_last"},  32'(c_last),  32'(c1));
    end
  endtask

  initial begin
    int busy_seen, done_seen, edge_n;
    int done_edges[$];
    rst = 1'b0; start = 1'b0; palm_width = '0; sr = '0; sc = '0; ec = '0; pat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/busy",   32'(busy_a),   32'd0);
    check("reset/done",   32'(done_a),   32'd0);
    check("reset/rd_en",  32'(rd_en_a),  32'd0);
    check("reset/rd_row", 32'(rd_row_a), 32'd0);
    check("reset/rd_col", 32'(rd_col_a), 32'd0);
    check("reset/status", 32'(st_a),     32'd0);
    rst = 1'b1;

    // Five-band split, all foreground: 32 rows x 50 cols, 320 per band.
    pat = 0;
    run_scan("five_band", 8'd40, 8'd10, 8'd59, 8'd50, 1600, 1603, 5'b11111, 5'b11111, 5'b11111);

    // Fist: only the middle band (cols 30..39) is foreground.
    pat = 1;
    run_scan("fist", 8'd40, 8'd10, 8'd59, 8'd50, 1600, 1603, 5'b00100, 5'b00100, 5'b00100);

    // Reset in the middle of a scan.
    pat = 0;
    @(negedge clk);
    sr = 8'd40; sc = 8'd10; ec = 8'd59; palm_width = 8'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst/pre_busy",  32'(busy_a),  32'd1);
    check("midrst/pre_rd_en", 32'(rd_en_a), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst/busy",   32'(busy_a),   32'd0);
    check("midrst/done",   32'(done_a),   32'd0);
    check("midrst/rd_en",  32'(rd_en_a),  32'd0);
    check("midrst/rd_row", 32'(rd_row_a), 32'd0);
    check("midrst/rd_col", 32'(rd_col_a), 32'd0);
    check("midrst/status", 32'(st_a),     32'd0);
    rst = 1'b1;
    busy_seen = 0; done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a) busy_seen++;
      if (done_a) done_seen++;
    end
    check("midrst/busy_after", 32'(busy_seen), 32'd0);
    check("midrst/done_after", 32'(done_seen), 32'd0);
    pat = 1;
    run_scan("fist_after_rst", 8'd40, 8'd10, 8'd59, 8'd50, 1600, 1603, 5'b00100, 5'b00100, 5'b00100);

    // Top clip: rows 0..4, cols 0..9, 10 pixels per band; threshold edge 10 vs 11.
    pat = 0;
    run_scan("top_clip", 8'd5, 8'd0, 8'd9, 8'd10, 50, 53, 5'b00000, 5'b11111, 5'b00000);

    // Degenerate requests: no reads, done after edge 2, status cleared.
    run_scan("degen_w0",  8'd40, 8'd10, 8'd59, 8'd0, 0, 2, 5'b00000, 5'b00000, 5'b00000);
    run_scan("degen_rev", 8'd40, 8'd20, 8'd10, 8'd5, 0, 2, 5'b00000, 5'b00000, 5'b00000);
    run_scan("degen_r0",  8'd0,  8'd10, 8'd59, 8'd50, 0, 2, 5'b00000, 5'b00000, 5'b00000);

    // start held high: ignored while busy, restarts only from IDLE (done at edges 2 and 6).
    @(negedge clk);
    sr = 8'd40; sc = 8'd10; ec = 8'd59; palm_width = 8'd0; start = 1'b1;
    @(posedge clk);
    busy_seen = 1;
    for (edge_n = 0; edge_n < 8; edge_n++) begin
      @(negedge clk);
      if (done_a) done_edges.push_back(edge_n);
      if (edge_n == 3) busy_seen = int'(busy_a);
      if (edge_n == 7) start = 1'b0;
      else @(posedge clk);
    end
    check("held/n_done", 32'(done_edges.size()), 32'd2);
    if (done_edges.size() == 2) begin
      check("held/done0", 32'(done_edges[0]), 32'd2);
      check("held/done1", 32'(done_edges[1]), 32'd6);
    end
    check("held/idle_gap", 32'(busy_seen), 32'd0);
    repeat (2) @(negedge clk);
    check("held/idle_end", 32'(busy_a), 32'd0);

    // Narrow palm: one column, everything lands in the thumb band.
    run_scan("narrow", 8'd40, 8'd20, 8'd20, 8'd1, 32, 35, 5'b00001, 5'b00001, 5'b00001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/finger_scan_ctrl.md
Name: finger_scan_ctrl

Overview:
- Sequencer that scans the finger strip directly above a detected palm in the binary hand frame buffer, one pixel read per cycle.
- Splits the palm column span into five equal bands: thumb, index, middle, ring, pinky, from start column to end column.
- Accumulates foreground pixels per band and, at the end of the scan, registers a five-bit extended/folded finger status.
- Sits between palm localisation (palm box) and the gesture classifier; is the only master of the frame-buffer read port while busy.

Parameters:
- FINGER_ROWS, 32, number of rows scanned above start_of_palm_r.
- THRESH, 16'd24, minimum foreground count for a band to read as extended.
- CNT_W, 16, per-band counter width; counters saturate.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- palm_width  in  8  zero forces the degenerate (empty) scan.
- start_of_palm_r  in  8  palm top row; sampled on start.
- start_of_palm_c, end_of_palm_c  in  8 each  palm column span, inclusive; sampled on start.
- rd_en  out  1  frame-buffer read strobe.
- rd_row, rd_col  out  8 each  read address.
- rd_data  in  1  pixel, valid exactly 1 cycle after rd_en.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when status is updated.
- thumb_status, index_status, middle_status, ring_status, pinky_status  out  1 each  1 = extended; held until next done.

Behaviour:
- Reset (rst=0 at edge): state IDLE; all outputs 0; band counters 0; rd_row/rd_col 0.
- States: IDLE -> SETUP -> SCAN -> DRAIN -> DECIDE -> DONE -> IDLE.
- IDLE:
  - start=1 latches the palm inputs and goes to SETUP.
  - start is ignored in all other states; there is no queuing.
- SETUP:
  - Computes row_lo = start_of_palm_r - FINGER_ROWS, clipped at 0, and row_hi = start_of_palm_r - 1.
  - Computes cols = end_c - start_c + 1 and clears all counters.
  - Degenerate case: palm_width=0, end_c<start_c, or start_of_palm_r=0. Goes straight to DECIDE with zero counts.
  - Otherwise goes to SCAN.
- SCAN:
  - rd_en=1 every cycle; addresses are row-major, from (row_lo, start_c) to (row_hi, end_c).
  - The column wraps to start_c with row+1.
  - Leaves SCAN after issuing the last address.
- Band tracking (no divider):
  - Keep band index b (0..4) and 9-bit accumulator acc, both reset to 0 at each row start.
  - After each column, acc += 5. If acc >= cols, then acc -= cols and b += 1 (saturating at 4).
  - b is delayed one cycle to align with rd_data.
- Accumulation: when the delayed rd_en is 1 and rd_data=1, cnt[b_d] += 1, saturating at 2^CNT_W-1.
- DRAIN: one cycle, rd_en=0, absorbs the final rd_data.
- DECIDE: status[i] = (cnt[i] >= THRESH), registered.
- DONE: done=1 for one cycle; status outputs take their new values on the same edge; then IDLE.
- Latency:
  - N = rows*cols reads, issued on the N cycles after SETUP.
  - done is high in the cycle following edge N+3, where edge 0 is the edge that samples start.
  - Degenerate case: done is high after edge 2.
- busy is 1 from SETUP through DONE inclusive.
- Reset mid-scan: abort immediately; status returns to 0; no done pulse.
- cols < 5: some bands receive no columns; their counts stay 0 and their status is 0.

Optional Feature:
- Macro: FINGER_COUNT_OUT_EN.
- When defined:
  - Adds output finger_count [2:0], the number of extended fingers.
  - Registered on the same edge as status; reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=0 for 2 cycles during SCAN -> all outputs 0, busy=0, no done pulse; next start scans normally.
- Five-band split: start_r=40, start_c=10, end_c=59 (cols=50), all foreground.
  - Reads cover rows 8..39 and cols 10..59: 1600 reads.
  - Each band counts 320; status 11111.
  - done asserted after edge 1603.
- Fist:
  - Same box; foreground only in cols 30..39 (band 2), rows 8..39.
  - middle=1, others 0 (status 00100); finger_count=1 if FINGER_COUNT_OUT_EN.
- Top clip and threshold edge:
  - start_r=5, cols 0..9, so rows 0..4 (50 reads).
  - Band 0 = cols 0..1, 10 pixels, with THRESH=10 -> thumb=1.
  - With THRESH=11 -> thumb=0.
- Degenerate:
  - palm_width=0 -> zero reads, done after edge 2, status 00000.
  - start held high throughout -> ignored while busy; the next scan starts only after IDLE is re-entered.
- Narrow palm: start_c=end_c=20 (cols=1), all foreground -> only band 0 counts; status 10000.
